hc4_cpu: RTL and testbench

- 8-bit stack-machine CPU with a 3-level operand stack (A top, B, C) and a 16-bit program counter.
- Uses one von Neumann memory (code and data) over a 16-bit address bus, an 8-bit bidirectional data bus, and active-low read/write strobes.
- Pairs with the companion asynchronous RAM block memory_8bit_2kbyte (2 KiB) on the system board; both are specified here.

---
 rtl/hc4_cpu.sv | 177 +++++++++++++++++
 tb/tb_hc4_cpu.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc4_cpu.sv
// hc4_cpu: 8-bit stack-machine CPU (3-level stack A/B/C, 16-bit PC) on a shared code/data bus,
// plus the companion 2 KiB asynchronous RAM memory_8bit_2kbyte.
module hc4_cpu #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        Reset,
    output logic [15:0] pc_out,
    output logic [7:0]  stackA_out,
    output logic [7:0]  stackB_out,
    output logic [7:0]  stackC_out,
    output logic        nRAM_RD,
    output logic        nRAM_WR,
    output logic [15:0] address_bus,
    inout  wire  [7:0]  data_bus
);

    typedef enum logic [2:0] {FETCH, EXEC, IMM, READ, WRITE} state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [7:0]  a, b, c, ir;
    logic [7:0]  a_n, b_n, c_n, ir_n;
    logic        z_flag, cy_flag, z_n, cy_n;
    logic        rd_q, wr_q;
    logic [8:0]  sum, diff;
    logic [7:0]  alu;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            a       <= 8'h00;
            b       <= 8'h00;
            c       <= 8'h00;
            ir      <= 8'h00;
            z_flag  <= 1'b0;
            cy_flag <= 1'b0;
            rd_q    <= 1'b1;
            wr_q    <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            a       <= a_n;
            b       <= b_n;
            c       <= c_n;
            ir      <= ir_n;
            z_flag  <= z_n;
            cy_flag <= cy_n;
            // strobes come straight from flops so they cannot glitch on decode
            rd_q    <= (state_n == FETCH) || (state_n == IMM) || (state_n == READ);
            wr_q    <= (state_n == WRITE);
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        a_n     = a;
        b_n     = b;
        c_n     = c;
        ir_n    = ir;
        z_n     = z_flag;
        cy_n    = cy_flag;
        sum     = {1'b0, b} + {1'b0, a};
        diff    = {1'b0, b} - {1'b0, a};
        alu     = a;
        case (state)
            FETCH: begin
                ir_n    = data_bus;
                pc_n    = pc + 16'd1;
                state_n = EXEC;
            end
            EXEC: begin
                state_n = FETCH;
                casez (ir)
                    8'b0001_????: begin
                        a_n = {4'h0, ir[3:0]};
                        b_n = a;
                        c_n = b;
                    end
                    8'h20: state_n = IMM;
                    8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35: begin
                        case (ir[2:0])
                            3'd0: begin alu = sum[7:0];  cy_n = sum[8];  end
                            3'd1: begin alu = diff[7:0]; cy_n = diff[8]; end
                            3'd2: alu = b & a;
                            3'd3: alu = b | a;
                            3'd4: alu = b ^ a;
                            default: alu = ~a;
                        endcase
                        z_n = (alu == 8'h00);
                        a_n = alu;
                        // NOT is unary and leaves B/C in place
                        if (ir[2:0] != 3'd5) b_n = c;
                    end
                    8'h40: state_n = READ;
                    8'h41: state_n = WRITE;
                    8'h50, 8'h51, 8'h52: begin
                        if ((ir == 8'h50) || (ir == 8'h51 && z_flag) || (ir == 8'h52 && cy_flag))
                            pc_n = {b, a};
                        a_n = c;
                        b_n = c;
                    end
                    8'h60: begin
                        b_n = a;
                        c_n = b;
                    end
                    8'h61: begin
                        a_n = b;
                        b_n = a;
                    end
                    8'h62: begin
                        a_n = b;
                        b_n = c;
                    end
                    default: ;
                endcase
            end
            IMM: begin
                a_n     = data_bus;
                b_n     = a;
                c_n     = b;
                pc_n    = pc + 16'd1;
                state_n = FETCH;
            end
            READ: begin
                a_n     = data_bus;
                b_n     = c;
                state_n = FETCH;
            end
            WRITE: begin
                a_n     = c;
                b_n     = c;
                state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    // Reset gates the bus combinationally so an aborted write releases immediately
    assign address_bus = Reset ? 16'h0000 :
                         ((state == READ) || (state == WRITE)) ? {b, a} : pc;
    assign nRAM_RD     = ~(rd_q & ~Reset);
    assign nRAM_WR     = ~(wr_q & ~Reset);
    assign data_bus    = (wr_q & ~Reset) ? c : 8'hzz;

    assign pc_out     = pc;
    assign stackA_out = a;
    assign stackB_out = b;
    assign stackC_out = c;

endmodule

module memory_8bit_2kbyte (
    input  logic [15:0] address,
    inout  wire  [7:0]  data_bus,
    input  logic        nchip_enable,
    input  logic        nwrite_enable,
    input  logic        nread_enable
);

    logic [7:0] mem [0:2047];
    logic       unused_addr_hi;

    // only 11 address bits decode; the upper bits alias
    assign unused_addr_hi = ^address[15:11];

    assign data_bus = (!nchip_enable && !nread_enable && nwrite_enable) ?
                      mem[address[10:0]] : 8'hzz;

    always_latch begin
        if (!nchip_enable && !nwrite_enable)
            mem[address[10:0]] <= data_bus;
    end

endmodule

// File: tb/tb_hc4_cpu.sv
// Scoreboard bench for hc4_cpu: stimulus queues expected values, monitors pop and compare.
module tb_hc4_cpu;

    logic        clk;
    logic        Reset;
    logic [15:0] pc_out, address_bus;
    logic [7:0]  stackA_out, stackB_out, stackC_out;
    logic        nRAM_RD, nRAM_WR;
    wire  [7:0]  data_bus;

    logic        ld;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_we_n;
    logic [15:0] mem_addr;
    logic        mem_we_n, mem_re_n;

    hc4_cpu #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .Reset(Reset), .pc_out(pc_out),
        .stackA_out(stackA_out), .stackB_out(stackB_out), .stackC_out(stackC_out),
        .nRAM_RD(nRAM_RD), .nRAM_WR(nRAM_WR),
        .address_bus(address_bus), .data_bus(data_bus)
    );

    assign mem_addr = ld ? ld_addr : address_bus;
    assign mem_we_n = ld ? ld_we_n : nRAM_WR;
    assign mem_re_n = ld ? 1'b1    : nRAM_RD;
    assign data_bus = ld ? ld_data : 8'hzz;

    memory_8bit_2kbyte mem_i (
        .address(mem_addr), .data_bus(data_bus), .nchip_enable(1'b0),
        .nwrite_enable(mem_we_n), .nread_enable(mem_re_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_PC = 0, S_A = 1, S_B = 2, S_C = 3, S_RD = 4, S_WR = 5,
                   S_ADDR = 6, S_Z = 7, S_CY = 8, S_MEM0 = 9;

    typedef struct {
        int          sel;
        logic [15:0] val;
        string       nm;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    exp_t chk_q[$];
    wr_t  wr_q[$];
    int   total = 0;
    int   bad   = 0;
    event chk_ev;

    task automatic expect_val(input int sel, input logic [15:0] val, input string nm);
        exp_t e;
        e.sel = sel; e.val = val; e.nm = nm;
        chk_q.push_back(e);
    endtask

    task automatic expect_write(input logic [15:0] addr, input logic [7:0] data);
        wr_t w;
        w.addr = addr; w.data = data;
        wr_q.push_back(w);
    endtask

    task automatic sample();
        -> chk_ev;
        #1;
    endtask

    // state monitor: compares every queued expectation when the stimulus asks for a sample
    initial begin
        forever begin
            @(chk_ev);
            while (chk_q.size() > 0) begin
                exp_t        e;
                logic [15:0] act;
                e = chk_q.pop_front();
                case (e.sel)
                    S_PC:    act = pc_out;
                    S_A:     act = {8'h00, stackA_out};
                    S_B:     act = {8'h00, stackB_out};
                    S_C:     act = {8'h00, stackC_out};
                    S_RD:    act = {15'h0, nRAM_RD};
                    S_WR:    act = {15'h0, nRAM_WR};
                    S_ADDR:  act = address_bus;
                    S_Z:     act = {15'h0, dut.z_flag};
                    S_CY:    act = {15'h0, dut.cy_flag};
                    default: act = {8'h00, mem_i.mem[0]};
                endcase
                total++;
                if (act !== e.val) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", e.nm, act, e.val);
                end
            end
        end
    end

    // bus monitor: every write cycle must match the next queued write; strobes never overlap
    always @(negedge clk) begin
        if (!Reset && !ld) begin
            total++;
            if (!nRAM_RD && !nRAM_WR) begin
                bad++;
                $display("FAIL strobe_overlap: got rd=%b wr=%b want not both low", nRAM_RD, nRAM_WR);
            end
            if (!nRAM_WR) begin
                total++;
                if (wr_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got addr=%h data=%h want no write", address_bus, data_bus);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    if (address_bus !== w.addr || data_bus !== w.data) begin
                        bad++;
                        $display("FAIL write_cycle: got addr=%h data=%h want addr=%h data=%h",
                                 address_bus, data_bus, w.addr, w.data);
                    end
                end
            end
        end
    end

    task automatic poke(input logic [15:0] addr, input logic [7:0] data);
        ld_addr = addr;
        ld_data = data;
        #1 ld_we_n = 1'b0;
        #1 ld_we_n = 1'b1;
        #1;
    endtask

    task automatic load_prog(input logic [7:0] prog[$]);
        Reset = 1'b1;
        ld    = 1'b1;
        for (int i = 0; i < prog.size(); i++) poke(16'(i), prog[i]);
        ld = 1'b0;
        #1;
    endtask

    task automatic start_cpu();
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset   = 1'b1;
        ld      = 1'b1;
        ld_addr = 16'h0000;
        ld_data = 8'h00;
        ld_we_n = 1'b1;
        for (int i = 0; i < 2048; i++) poke(16'(i), 8'h00);
        ld = 1'b0;
        #1;

        // reset state and first program: 13 14 30
        load_prog('{8'h13, 8'h14, 8'h30});
        expect_val(S_PC, 16'h0000, "rst_pc");
        expect_val(S_A, 16'h0000, "rst_a");
        expect_val(S_B, 16'h0000, "rst_b");
        expect_val(S_C, 16'h0000, "rst_c");
        expect_val(S_RD, 16'h0001, "rst_nrd");
        expect_val(S_WR, 16'h0001, "rst_nwr");
        expect_val(S_ADDR, 16'h0000, "rst_addr");
        sample();
        start_cpu();
        clocks(6);
        expect_val(S_A, 16'h0007, "add_a");
        expect_val(S_B, 16'h0000, "add_b");
        expect_val(S_PC, 16'h0003, "add_pc");
        expect_val(S_Z, 16'h0000, "add_z");
        sample();

        // LI8 and carry: 20 FF 10 30 1F 30
        load_prog('{8'h20, 8'hFF, 8'h10, 8'h30, 8'h1F, 8'h30});
        start_cpu();
        clocks(3);
        expect_val(S_A, 16'h00FF, "li8_a");
        expect_val(S_PC, 16'h0002, "li8_pc");
        sample();
        clocks(4);
        expect_val(S_A, 16'h00FF, "add0_a");
        expect_val(S_CY, 16'h0000, "add0_cy");
        sample();
        clocks(4);
        expect_val(S_A, 16'h000E, "addc_a");
        expect_val(S_CY, 16'h0001, "addc_cy");
        expect_val(S_Z, 16'h0000, "addc_z");
        sample();

        // store: 1A 10 10 41
        load_prog('{8'h1A, 8'h10, 8'h10, 8'h41});
        expect_write(16'h0000, 8'h0A);
        start_cpu();
        clocks(9);
        expect_val(S_MEM0, 16'h000A, "st_mem0");
        expect_val(S_A, 16'h000A, "st_a");
        expect_val(S_B, 16'h000A, "st_b");
        expect_val(S_C, 16'h000A, "st_c");
        expect_val(S_PC, 16'h0004, "st_pc");
        expect_val(S_WR, 16'h0001, "st_nwr_after");
        sample();

        // load from 0x0100: 20 5A 11 10 41 11 10 40
        Reset = 1'b1;
        ld = 1'b1;
        poke(16'h0100, 8'h5A);
        ld = 1'b0;
        load_prog('{8'h20, 8'h5A, 8'h11, 8'h10, 8'h41, 8'h11, 8'h10, 8'h40});
        expect_write(16'h0100, 8'h5A);
        start_cpu();
        clocks(16);
        expect_val(S_ADDR, 16'h0100, "ld_addr");
        expect_val(S_RD, 16'h0000, "ld_nrd");
        sample();
        clocks(1);
        expect_val(S_A, 16'h005A, "ld_a");
        expect_val(S_B, 16'h005A, "ld_b");
        expect_val(S_PC, 16'h0008, "ld_pc");
        sample();

        // JZ taken: 15 15 31 10 20 40 51 -> target {B,A} = 0x0040
        load_prog('{8'h15, 8'h15, 8'h31, 8'h10, 8'h20, 8'h40, 8'h51});
        start_cpu();
        clocks(6);
        expect_val(S_A, 16'h0000, "sub0_a");
        expect_val(S_Z, 16'h0001, "sub0_z");
        expect_val(S_CY, 16'h0000, "sub0_cy");
        sample();
        clocks(7);
        expect_val(S_PC, 16'h0040, "jz_taken_pc");
        expect_val(S_A, 16'h0000, "jz_taken_a");
        sample();

        // JZ not taken: 16 15 31 10 20 40 51
        load_prog('{8'h16, 8'h15, 8'h31, 8'h10, 8'h20, 8'h40, 8'h51});
        start_cpu();
        clocks(6);
        expect_val(S_A, 16'h0001, "sub1_a");
        expect_val(S_Z, 16'h0000, "sub1_z");
        sample();
        clocks(7);
        expect_val(S_PC, 16'h0007, "jz_fall_pc");
        sample();

        // reset during WRITE of ST: 1A 10 10 41
        load_prog('{8'h1A, 8'h10, 8'h10, 8'h41});
        start_cpu();
        clocks(8);
        expect_val(S_WR, 16'h0000, "wr_active_nwr");
        expect_val(S_ADDR, 16'h0000, "wr_active_addr");
        sample();
        Reset = 1'b1;
        #1;
        expect_val(S_WR, 16'h0001, "abort_nwr");
        expect_val(S_RD, 16'h0001, "abort_nrd");
        expect_val(S_PC, 16'h0000, "abort_pc");
        expect_val(S_A, 16'h0000, "abort_a");
        expect_val(S_B, 16'h0000, "abort_b");
        expect_val(S_C, 16'h0000, "abort_c");
        sample();
        clocks(2);

        total++;
        if (wr_q.size() != 0) begin
            bad++;
            $display("FAIL missing_write: got %0d pending want 0", wr_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
